frame_ingest_scheduler: RTL and testbench
=========================================

Name: frame_ingest_scheduler

Overview:
- Frame-level sequencer between the AXI pixel write path and the lane-detection CNN core.
- Tracks pixels pushed into the input pixel FIFO and launches the network once enough pixels are buffered.
- Gates FIFO reads by the network and counts network result words.
- Raises a host interrupt on frame completion; records protocol errors in sticky flags.

Parameters:
IN_WIDTH, 512, frame width in pixels
IN_HEIGHT, 256, frame height in pixels
START_THRESH, 512, buffered pixels required before net_start (1..IN_WIDTH*IN_HEIGHT)
FIFO_DEPTH, 1024, input pixel FIFO capacity in pixels
OUT_WORDS, 8192, result words produced per frame
FIFO_CNT_W, 11, width of the FIFO occupancy input (holds 0..FIFO_DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
pix_valid  in  1  one 24-bit pixel written into input FIFO this cycle
pix_first  in  1  qualifies pix_valid: first pixel of a frame
in_fifo_count  in  FIFO_CNT_W  input FIFO occupancy, sampled the same cycle as pix_valid
out_valid  in  1  one network result word produced this cycle
sw_abort  in  1  host abort, single-cycle pulse
irq_clr  in  1  host interrupt clear, single-cycle pulse
err_clr  in  1  clears sticky error flags
net_start  out  1  one-cycle pulse: start CNN on current frame
net_abort  out  1  one-cycle pulse: flush CNN pipeline
fifo_rd_gate  out  1  network allowed to pop the input FIFO
busy  out  1  state != IDLE
irq  out  1  level interrupt, frame done
frame_cnt  out  16  completed frames, wraps at 65535->0
err_overflow  out  1  sticky: pix_valid while in_fifo_count == FIFO_DEPTH
err_sync  out  1  sticky: frame protocol violation

Behaviour:
- Reset: state IDLE; all outputs 0; pix_cnt, out_cnt, frame_cnt = 0. All outputs are registered.
- FRAME_PIX = IN_WIDTH*IN_HEIGHT.
- pix_cnt is $clog2(FRAME_PIX+1) bits; out_cnt is $clog2(OUT_WORDS+1) bits. Neither counter exceeds its limit.
- States and transitions:
  - IDLE:
    - pix_valid & pix_first -> FILL, pix_cnt=1.
    - pix_valid & ~pix_first -> err_sync set, pixel ignored, stay IDLE.
  - FILL: each pix_valid increments pix_cnt.
    - When the incremented value reaches START_THRESH or FRAME_PIX -> RUN.
    - net_start pulses 1 in the first RUN cycle; fifo_rd_gate = 1 from that cycle.
  - RUN: pixels keep counting. When pix_cnt reaches FRAME_PIX -> WAIT_OUT.
  - Output counting: out_valid increments out_cnt in RUN and WAIT_OUT.
    - out_valid in IDLE or FILL -> err_sync set, not counted.
  - WAIT_OUT: when the incremented out_cnt equals OUT_WORDS -> DONE.
    - If out_cnt reaches OUT_WORDS while still in RUN (pixels outstanding), set err_sync and stop counting outputs.
  - DONE (one cycle): irq set, frame_cnt+1, fifo_rd_gate=0, pix_cnt and out_cnt cleared -> IDLE.
- pix_first & pix_valid in FILL/RUN:
  - err_sync set; net_abort pulses if net_start was already issued.
  - out_cnt=0, pix_cnt=1, fifo_rd_gate=0, next state FILL (frame restart).
- pix_valid (any) in WAIT_OUT/DONE: err_sync set; pixel not counted.
- Overflow: pix_valid with in_fifo_count == FIFO_DEPTH sets err_overflow. The pixel is still counted, keeping alignment with the write path.
- irq: set on DONE, cleared by irq_clr. Simultaneous set and clear -> set wins.
- err_clr clears both sticky flags. Simultaneous error event wins.
- sw_abort has priority over all events:
  - Next state IDLE; pix_cnt and out_cnt cleared; fifo_rd_gate=0.
  - net_abort pulses if state was RUN/WAIT_OUT/DONE.
  - irq, frame_cnt and error flags unchanged.
- net_start and net_abort never both 1 in the same cycle.

Test Plan:
Test parameters for all scenarios: IN_WIDTH=8, IN_HEIGHT=4, START_THRESH=8, OUT_WORDS=4.
1. Nominal frame: 32 pix_valid (first flagged), then 4 out_valid -> net_start once (the cycle after 8th pixel), irq=1 after 4th output, frame_cnt=1, busy=0, no errors.
2. Back-to-back frames with irq_clr asserted in the same cycle as DONE of frame 2 -> irq stays 1, frame_cnt=2.
3. pix_first at pixel 20 of a frame -> err_sync=1, net_abort one pulse, pix_cnt=1, state FILL; next frame completes normally, frame_cnt increments once.
4. pix_valid with in_fifo_count=1024 (FIFO_DEPTH default) -> err_overflow=1, frame still completes; err_clr -> err_overflow=0.
5. sw_abort in WAIT_OUT after 2 outputs -> net_abort pulse, busy=0 next cycle, irq=0, frame_cnt unchanged; stray out_valid in IDLE -> err_sync=1.
6. rst_n asserted mid-RUN -> all outputs 0 immediately (asynchronous), counters 0; pix_valid without pix_first afterwards -> err_sync=1, state IDLE.

Source files
------------

// File: rtl/frame_ingest_scheduler_if.sv
// Signal bundle between the pixel write path / host side and the frame ingest scheduler.
// The master side drives pixel, result and host pulses; the slave side (the scheduler) drives status.
interface frame_ingest_scheduler_if #(
    parameter int FIFO_CNT_W = 11
);
    logic                  pix_valid;
    logic                  pix_first;
    logic [FIFO_CNT_W-1:0] in_fifo_count;
    logic                  out_valid;
    logic                  sw_abort;
    logic                  irq_clr;
    logic                  err_clr;
    logic                  net_start;
    logic                  net_abort;
    logic                  fifo_rd_gate;
    logic                  busy;
    logic                  irq;
    logic [15:0]           frame_cnt;
    logic                  err_overflow;
    logic                  err_sync;

    modport master (
        output pix_valid, pix_first, in_fifo_count, out_valid, sw_abort, irq_clr, err_clr,
        input  net_start, net_abort, fifo_rd_gate, busy, irq, frame_cnt, err_overflow, err_sync
    );

    modport slave (
        input  pix_valid, pix_first, in_fifo_count, out_valid, sw_abort, irq_clr, err_clr,
        output net_start, net_abort, fifo_rd_gate, busy, irq, frame_cnt, err_overflow, err_sync
    );
endinterface

// File: rtl/frame_ingest_scheduler.sv
// Frame-level sequencer: counts buffered pixels, launches the CNN, gates FIFO reads,
// counts result words, raises the frame-done interrupt and keeps sticky protocol error flags.
module frame_ingest_scheduler #(
    parameter int IN_WIDTH     = 512,
    parameter int IN_HEIGHT    = 256,
    parameter int START_THRESH = 512,
    parameter int FIFO_DEPTH   = 1024,
    parameter int OUT_WORDS    = 8192,
    parameter int FIFO_CNT_W   = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    frame_ingest_scheduler_if.slave bus_if
);
    localparam int FRAME_PIX = IN_WIDTH * IN_HEIGHT;
    localparam int PIX_W     = $clog2(FRAME_PIX + 1);
    localparam int OUT_W     = $clog2(OUT_WORDS + 1);
    localparam logic [PIX_W-1:0]      PIX_LAST  = PIX_W'(FRAME_PIX);
    localparam logic [PIX_W-1:0]      PIX_THR   = PIX_W'(START_THRESH);
    localparam logic [PIX_W-1:0]      PIX_ONE   = PIX_W'(1);
    localparam logic [OUT_W-1:0]      OUT_LAST  = OUT_W'(OUT_WORDS);
    localparam logic [FIFO_CNT_W-1:0] FIFO_FULL = FIFO_CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FILL     = 3'd1,
        S_RUN      = 3'd2,
        S_WAIT_OUT = 3'd3,
        S_DONE     = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [OUT_W-1:0] out_cnt_q, out_cnt_d;
    logic             net_start_q, net_start_d, net_abort_q, net_abort_d;
    logic             rd_gate_q, rd_gate_d, busy_q, busy_d, irq_q, irq_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             err_ovf_q, err_ovf_d, err_sync_q, err_sync_d;

    logic             restart_s, sync_ev_s, ovf_ev_s, out_hit_s;
    logic [PIX_W-1:0] pix_inc_s, pix_sat_s;
    logic [OUT_W-1:0] out_inc_s;

    // Next-state, pixel/result counters and protocol-violation detection.
    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        out_cnt_d = out_cnt_q;
        sync_ev_s = 1'b0;
        pix_inc_s = pix_cnt_q + {{(PIX_W-1){1'b0}}, bus_if.pix_valid};
        out_inc_s = out_cnt_q + {{(OUT_W-1){1'b0}}, bus_if.out_valid};
        // A full pixel count never wraps; a full result count stops counting.
        pix_sat_s = (pix_cnt_q == PIX_LAST) ? pix_cnt_q : pix_inc_s;
        out_hit_s = bus_if.out_valid && (out_cnt_q != OUT_LAST) && (out_inc_s == OUT_LAST);
        restart_s = bus_if.pix_valid && bus_if.pix_first &&
                    ((state_q == S_FILL) || (state_q == S_RUN));
        if (bus_if.sw_abort) begin
            state_d   = S_IDLE;
            pix_cnt_d = '0;
            out_cnt_d = '0;
        end else if (restart_s) begin
            sync_ev_s = 1'b1;
            state_d   = S_FILL;
            pix_cnt_d = PIX_ONE;
            out_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sync_ev_s = (bus_if.pix_valid && !bus_if.pix_first) || bus_if.out_valid;
                    if (bus_if.pix_valid && bus_if.pix_first) begin
                        state_d   = S_FILL;
                        pix_cnt_d = PIX_ONE;
                    end else begin
                        state_d   = S_IDLE;
                    end
                end
                S_FILL: begin
                    sync_ev_s = bus_if.out_valid;
                    pix_cnt_d = pix_inc_s;
                    if ((pix_inc_s >= PIX_THR) || (pix_inc_s == PIX_LAST)) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_FILL;
                    end
                end
                S_RUN: begin
                    pix_cnt_d = pix_sat_s;
                    if (bus_if.out_valid && (out_cnt_q != OUT_LAST)) begin
                        out_cnt_d = out_inc_s;
                    end else begin
                        out_cnt_d = out_cnt_q;
                    end
                    sync_ev_s = (bus_if.pix_valid && (pix_cnt_q == PIX_LAST)) ||
                                (out_hit_s && (pix_sat_s != PIX_LAST));
                    state_d   = (pix_sat_s == PIX_LAST) ? S_WAIT_OUT : S_RUN;
                end
                S_WAIT_OUT: begin
                    sync_ev_s = bus_if.pix_valid;
                    if (bus_if.out_valid && (out_cnt_q != OUT_LAST)) begin
                        out_cnt_d = out_inc_s;
                    end else begin
                        out_cnt_d = out_cnt_q;
                    end
                    state_d = (out_cnt_d == OUT_LAST) ? S_DONE : S_WAIT_OUT;
                end
                S_DONE: begin
                    sync_ev_s = bus_if.pix_valid;
                    state_d   = S_IDLE;
                    pix_cnt_d = '0;
                    out_cnt_d = '0;
                end
                default: begin
                    state_d   = S_IDLE;
                    pix_cnt_d = '0;
                    out_cnt_d = '0;
                end
            endcase
        end
    end

    // Next values of the registered outputs, derived from the state transition.
    always_comb begin
        net_start_d = 1'b0;
        net_abort_d = 1'b0;
        ovf_ev_s    = !bus_if.sw_abort && bus_if.pix_valid && (bus_if.in_fifo_count == FIFO_FULL);
        // The network only needs flushing once it has been started on this frame.
        if (bus_if.sw_abort) begin
            net_abort_d = (state_q == S_RUN) || (state_q == S_WAIT_OUT) || (state_q == S_DONE);
        end else if (restart_s) begin
            net_abort_d = (state_q == S_RUN);
        end else begin
            net_start_d = (state_d == S_RUN) && (state_q != S_RUN);
        end
        rd_gate_d = (state_d == S_RUN) || (state_d == S_WAIT_OUT);
        busy_d    = (state_d != S_IDLE);
        if ((state_q == S_DONE) && !bus_if.sw_abort) begin
            irq_d       = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            irq_d       = bus_if.irq_clr ? 1'b0 : irq_q;
            frame_cnt_d = frame_cnt_q;
        end
        if (ovf_ev_s) begin
            err_ovf_d = 1'b1;
        end else begin
            err_ovf_d = bus_if.err_clr ? 1'b0 : err_ovf_q;
        end
        if (sync_ev_s) begin
            err_sync_d = 1'b1;
        end else begin
            err_sync_d = bus_if.err_clr ? 1'b0 : err_sync_q;
        end
    end

    // State, counters and all outputs registered with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pix_cnt_q   <= '0;
            out_cnt_q   <= '0;
            net_start_q <= 1'b0;
            net_abort_q <= 1'b0;
            rd_gate_q   <= 1'b0;
            busy_q      <= 1'b0;
            irq_q       <= 1'b0;
            frame_cnt_q <= 16'd0;
            err_ovf_q   <= 1'b0;
            err_sync_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            out_cnt_q   <= out_cnt_d;
            net_start_q <= net_start_d;
            net_abort_q <= net_abort_d;
            rd_gate_q   <= rd_gate_d;
            busy_q      <= busy_d;
            irq_q       <= irq_d;
            frame_cnt_q <= frame_cnt_d;
            err_ovf_q   <= err_ovf_d;
            err_sync_q  <= err_sync_d;
        end
    end

    assign bus_if.net_start    = net_start_q;
    assign bus_if.net_abort    = net_abort_q;
    assign bus_if.fifo_rd_gate = rd_gate_q;
    assign bus_if.busy         = busy_q;
    assign bus_if.irq          = irq_q;
    assign bus_if.frame_cnt    = frame_cnt_q;
    assign bus_if.err_overflow = err_ovf_q;
    assign bus_if.err_sync     = err_sync_q;
endmodule

// File: tb/tb_frame_ingest_scheduler.sv
// Self-checking bench for frame_ingest_scheduler: directed frame scenarios plus random traffic,
// compared every cycle against a frame-level behavioural model.
module tb_frame_ingest_scheduler;
    localparam int W = 8, H = 4, THR = 8, FD = 1024, OW = 4, CW = 11;
    localparam int FP = W * H;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0, errors = 0, ns_seen = 0;

    frame_ingest_scheduler_if #(.FIFO_CNT_W(CW)) bus_if ();

    frame_ingest_scheduler #(
        .IN_WIDTH(W), .IN_HEIGHT(H), .START_THRESH(THR),
        .FIFO_DEPTH(FD), .OUT_WORDS(OW), .FIFO_CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus_if(bus_if)
    );

    always #5 clk = ~clk;

    // Model: a frame is active once its first pixel arrives, launched once THR pixels are buffered,
    // drained once all FP pixels are in, and finishing during the single cycle after OW results.
    bit          m_active, m_launched, m_finish;
    int          m_pix, m_outs;
    logic        e_start, e_abort, e_gate, e_busy, e_irq, e_ovf, e_sync;
    logic [15:0] e_frame;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void clear_frame();
        m_active = 1'b0; m_launched = 1'b0; m_finish = 1'b0; m_pix = 0; m_outs = 0;
    endfunction

    function automatic void model_reset();
        clear_frame();
        e_start = 1'b0; e_abort = 1'b0; e_gate = 1'b0; e_busy = 1'b0;
        e_irq = 1'b0; e_ovf = 1'b0; e_sync = 1'b0; e_frame = 16'd0;
    endfunction

    function automatic void model_step();
        bit pv = bus_if.pix_valid, pf = bus_if.pix_first, ov = bus_if.out_valid;
        bit ab = bus_if.sw_abort, was_done = m_finish;
        bit sync_ev = 1'b0, ovf_ev = 1'b0;
        e_start = 1'b0;
        e_abort = 1'b0;
        if (ab) begin
            e_abort = m_launched || m_finish;
            clear_frame();
        end else begin
            ovf_ev = pv && (int'(bus_if.in_fifo_count) == FD);
            if (m_finish) begin
                sync_ev = pv;
                clear_frame();
            end else if (!m_active) begin
                sync_ev = (pv && !pf) || ov;
                if (pv && pf) begin m_active = 1'b1; m_pix = 1; end
            end else if (m_launched && m_pix == FP) begin
                sync_ev = pv;
                if (ov && m_outs < OW) m_outs++;
                if (m_outs == OW) m_finish = 1'b1;
            end else if (pv && pf) begin
                sync_ev = 1'b1;
                e_abort = m_launched;
                m_launched = 1'b0; m_pix = 1; m_outs = 0;
            end else if (!m_launched) begin
                sync_ev = ov;
                m_pix += int'(pv);
                if (m_pix >= THR) begin m_launched = 1'b1; e_start = 1'b1; end
            end else begin
                m_pix += int'(pv);
                if (ov && m_outs < OW) begin
                    m_outs++;
                    if (m_outs == OW && m_pix < FP) sync_ev = 1'b1;
                end
            end
        end
        if (was_done && !ab) begin e_irq = 1'b1; e_frame = e_frame + 16'd1; end
        else if (bus_if.irq_clr) e_irq = 1'b0;
        if (ovf_ev) e_ovf = 1'b1; else if (bus_if.err_clr) e_ovf = 1'b0;
        if (sync_ev) e_sync = 1'b1; else if (bus_if.err_clr) e_sync = 1'b0;
        e_busy = m_active;
        e_gate = m_launched && !m_finish;
    endfunction

    // Advance the model on each active edge and compare every output shortly after it.
    always @(posedge clk) begin
        if (rst_n) begin
            model_step();
            #1;
            chk("net_start", bus_if.net_start, e_start);
            chk("net_abort", bus_if.net_abort, e_abort);
            chk("fifo_rd_gate", bus_if.fifo_rd_gate, e_gate);
            chk("busy", bus_if.busy, e_busy);
            chk("irq", bus_if.irq, e_irq);
            chk("frame_cnt", bus_if.frame_cnt, e_frame);
            chk("err_overflow", bus_if.err_overflow, e_ovf);
            chk("err_sync", bus_if.err_sync, e_sync);
            if (bus_if.net_start) ns_seen++;
        end
    end

    task automatic drive(input bit pv, input bit pf, input int cnt, input bit ov,
                         input bit ab, input bit ic, input bit ec);
        bus_if.pix_valid     = pv;
        bus_if.pix_first     = pf;
        bus_if.in_fifo_count = CW'(cnt);
        bus_if.out_valid     = ov;
        bus_if.sw_abort      = ab;
        bus_if.irq_clr       = ic;
        bus_if.err_clr       = ec;
        @(negedge clk);
    endtask

    task automatic idle(input bit ic, input bit ec);
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0, ic, ec);
    endtask

    task automatic send_pixels(input int n, input bit first);
        for (int i = 0; i < n; i++) drive(1'b1, first && (i == 0), i % 512, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_outs(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " net_start"}, bus_if.net_start, 1'b0);
        chk({tag, " net_abort"}, bus_if.net_abort, 1'b0);
        chk({tag, " fifo_rd_gate"}, bus_if.fifo_rd_gate, 1'b0);
        chk({tag, " busy"}, bus_if.busy, 1'b0);
        chk({tag, " irq"}, bus_if.irq, 1'b0);
        chk({tag, " frame_cnt"}, bus_if.frame_cnt, 16'd0);
        chk({tag, " err_overflow"}, bus_if.err_overflow, 1'b0);
        chk({tag, " err_sync"}, bus_if.err_sync, 1'b0);
    endtask

    initial begin
        bus_if.pix_valid = 1'b0; bus_if.pix_first = 1'b0; bus_if.in_fifo_count = '0;
        bus_if.out_valid = 1'b0; bus_if.sw_abort = 1'b0; bus_if.irq_clr = 1'b0; bus_if.err_clr = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        idle(1'b0, 1'b0);

        // Nominal frame: start the cycle after the 8th pixel, irq after the DONE cycle.
        send_pixels(7, 1'b1);
        chk("t1 no early start", bus_if.net_start, 1'b0);
        send_pixels(1, 1'b0);
        chk("t1 start after 8th", bus_if.net_start, 1'b1);
        send_pixels(FP - 8, 1'b0);
        send_outs(OW);
        idle(1'b0, 1'b0);
        chk("t1 irq", bus_if.irq, 1'b1);
        chk("t1 frame_cnt", bus_if.frame_cnt, 16'd1);
        chk("t1 busy", bus_if.busy, 1'b0);
        chk("t1 errors", {bus_if.err_overflow, bus_if.err_sync}, 2'b00);
        chk("t1 start count", ns_seen, 1);

        // Second frame with irq_clr during its DONE cycle: set wins.
        idle(1'b1, 1'b0);
        chk("t2 irq cleared", bus_if.irq, 1'b0);
        send_pixels(FP, 1'b1);
        send_outs(OW);
        idle(1'b1, 1'b0);
        chk("t2 irq set wins", bus_if.irq, 1'b1);
        chk("t2 frame_cnt", bus_if.frame_cnt, 16'd2);

        // Restart via pix_first at pixel 20.
        idle(1'b1, 1'b0);
        send_pixels(19, 1'b1);
        drive(1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3 err_sync", bus_if.err_sync, 1'b1);
        chk("t3 net_abort", bus_if.net_abort, 1'b1);
        chk("t3 gate off", bus_if.fifo_rd_gate, 1'b0);
        send_pixels(FP - 1, 1'b0);
        send_outs(OW);
        idle(1'b0, 1'b0);
        chk("t3 frame_cnt", bus_if.frame_cnt, 16'd3);
        idle(1'b0, 1'b1);
        chk("t3 err_clr", bus_if.err_sync, 1'b0);

        // Overflowing pixel still counts toward the frame.
        send_pixels(9, 1'b1);
        drive(1'b1, 1'b0, FD, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4 err_overflow", bus_if.err_overflow, 1'b1);
        send_pixels(FP - 10, 1'b0);
        send_outs(OW);
        idle(1'b0, 1'b0);
        chk("t4 frame_cnt", bus_if.frame_cnt, 16'd4);
        idle(1'b0, 1'b1);
        chk("t4 err_clr", bus_if.err_overflow, 1'b0);

        // Host abort while waiting for results, then a stray result word in IDLE.
        idle(1'b1, 1'b0);
        send_pixels(FP, 1'b1);
        send_outs(2);
        drive(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5 net_abort", bus_if.net_abort, 1'b1);
        chk("t5 busy", bus_if.busy, 1'b0);
        chk("t5 irq", bus_if.irq, 1'b0);
        chk("t5 frame_cnt", bus_if.frame_cnt, 16'd4);
        send_outs(1);
        chk("t5 stray out", bus_if.err_sync, 1'b1);
        idle(1'b0, 1'b1);

        // Asynchronous reset in the middle of RUN.
        send_pixels(12, 1'b1);
        chk("t6 running", bus_if.fifo_rd_gate, 1'b1);
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk_all_zero("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6 err_sync", bus_if.err_sync, 1'b1);
        chk("t6 idle", bus_if.busy, 1'b0);

        // Random traffic, mostly well-formed frames with occasional protocol violations.
        for (int c = 0; c < 4000; c++) begin
            bit pv, pf, ov;
            int cnt;
            pv  = ($urandom_range(0, 99) < 60);
            pf  = pv && (!m_active ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 99) < 2));
            ov  = m_launched ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 3);
            cnt = ($urandom_range(0, 49) == 0) ? FD : int'($urandom_range(0, FD - 1));
            drive(pv, pf, cnt, ov, $urandom_range(0, 199) == 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
        end
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
